// File: rtl/mc_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mc_mem_responder
//  Purpose  : Memory-side responder for the multicycle processor's unified
//             instruction/data port. Word-addressed read/write requests are
//             captured while idle, serviced after a fixed LATENCY, and
//             acknowledged with a one-cycle ready pulse. Out-of-range and
//             simultaneous read+write requests are flagged with err.
//  Ports    : clk       - system clock, rising edge
//             reset     - synchronous, active-high reset
//             address   - 32-bit word index
//             data_in   - write data, sampled with the request
//             re / we   - read / write request levels, sampled when idle
//             data_out  - registered read data, valid with ready
//             ready     - one-cycle completion pulse
//             busy      - high while a captured request is outstanding
//             err       - error flag, valid with ready
//  Revision : 1.0 - initial release
// ============================================================================
module mc_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        re,
  input  logic        we,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0]  C_CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [31:0] C_DEPTH    = 32'(DEPTH);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_re;
  logic        r_we;

  logic [31:0] mem [DEPTH];

  logic              w_bad;
  logic              w_access;
  logic              w_wr_commit;
  logic              w_capture;
  logic [ADDR_W-1:0] w_idx;

  // Full 32-bit range check so upper address bits can never alias into the array.
  assign w_bad       = (r_re && r_we) || (r_addr >= C_DEPTH);
  assign w_idx       = r_addr[ADDR_W-1:0];
  // The access edge is the WAIT->RESP transition; r_cnt counts the remaining
  // waiting edges so that RESP is entered LATENCY edges after capture.
  assign w_access    = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_wr_commit = w_access && !w_bad && r_we;
  // New requests are accepted in IDLE and on the edge that leaves RESP.
  assign w_capture   = ((r_state == S_IDLE) || (r_state == S_RESP)) && (re || we);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= 32'd0;
      r_data   <= 32'd0;
      r_re     <= 1'b0;
      r_we     <= 1'b0;
      data_out <= 32'd0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_RESP: begin
          ready <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          r_state <= S_IDLE;
          if (w_capture) begin
            r_addr  <= address;
            r_data  <= data_in;
            r_re    <= re;
            r_we    <= we;
            r_cnt   <= C_CNT_LOAD;
            busy    <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_access) begin
            r_state <= S_RESP;
            ready   <= 1'b1;
            if (w_bad) begin
              data_out <= 32'd0;
              err      <= 1'b1;
            end else begin
              err <= 1'b0;
              if (r_re) begin
                data_out <= mem[w_idx];
              end
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          ready   <= 1'b0;
          busy    <= 1'b0;
          err     <= 1'b0;
        end
      endcase
    end
  end

  // Array kept in its own block without reset so it maps onto RAM; reset
  // still blocks a commit landing on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_commit) begin
      mem[w_idx] <= r_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_mem_responder
//  Purpose  : Self-checking bench for mc_mem_responder (LATENCY=2 and
//             LATENCY=1 instances) using per-instance expectation queues.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mc_mem_responder;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [31:0] address = 32'd0, data_in = 32'd0;
  logic        re = 1'b0, we = 1'b0;
  logic [31:0] data_out;
  logic        ready, busy, err;

  logic [31:0] address2 = 32'd0, data_in2 = 32'd0;
  logic        re2 = 1'b0, we2 = 1'b0;
  logic [31:0] data_out2;
  logic        ready2, busy2, err2;

  int checks = 0;
  int errors = 0;

  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] model_mem [256];
  logic [31:0] model_last = 32'd0;

  always #5 clk = ~clk;

  mc_mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .re(re), .we(we), .data_out(data_out), .ready(ready), .busy(busy), .err(err)
  );

  mc_mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .address(address2), .data_in(data_in2),
    .re(re2), .we(we2), .data_out(data_out2), .ready(ready2), .busy(busy2), .err(err2)
  );

  // Scoreboard: every ready pulse consumes one expectation.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      checks = checks + 1;
      if (q1.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb1_unexpected_ready: ready=1 with no outstanding request");
      end else begin
        exp_t x;
        x = q1.pop_front();
        checks = checks + 1;
        if (data_out !== x.d || err !== x.e) begin
          errors = errors + 1;
          $display("FAIL sb1_resp: data_out=%h err=%b expected data_out=%h err=%b",
                   data_out, err, x.d, x.e);
        end
      end
    end
    if (ready2 === 1'b1) begin
      checks = checks + 1;
      if (q2.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb2_unexpected_ready: ready=1 with no outstanding request");
      end else begin
        exp_t x;
        x = q2.pop_front();
        checks = checks + 1;
        if (data_out2 !== x.d || err2 !== x.e) begin
          errors = errors + 1;
          $display("FAIL sb2_resp: data_out=%h err=%b expected data_out=%h err=%b",
                   data_out2, err2, x.d, x.e);
        end
      end
    end
  end

  // Compute the expected response for dut (LATENCY=2) and queue it.
  task automatic expect1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t x;
    if ((r && w) || (a >= 32'd256)) begin
      x.d = 32'd0;
      x.e = 1'b1;
      model_last = 32'd0;
    end else if (r) begin
      x.d = model_mem[a[7:0]];
      x.e = 1'b0;
      model_last = x.d;
    end else begin
      x.d = model_last;
      x.e = 1'b0;
      model_mem[a[7:0]] = d;
    end
    q1.push_back(x);
  endtask

  // One complete request on dut: capture, release, wait for idle.
  task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    expect1(r, w, a, d);
    @(negedge clk);
    re = r; we = w; address = a; data_in = d;
    @(posedge clk);
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks = checks + 1;
    if (busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL req_timeout: busy=%b required 0 within 40 cycles", busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks = checks + 1;
    if ({ready, busy, err} !== 3'b000 || data_out !== 32'd0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: ready=%b busy=%b err=%b data_out=%h required all 0",
               ready, busy, err, data_out);
    end
    checks = checks + 1;
    if ({ready2, busy2, err2} !== 3'b000 || data_out2 !== 32'd0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs_l1: ready=%b busy=%b err=%b data_out=%h required all 0",
               ready2, busy2, err2, data_out2);
    end
    reset = 1'b0;
  endtask

  task automatic test_preload();
    req(1'b0, 1'b1, 32'd0, 32'h0000_0A00);
    req(1'b0, 1'b1, 32'd3, 32'h3333_0003);
    req(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    req(1'b0, 1'b1, 32'd9, 32'h1111_0009);
  endtask

  task automatic test_read_timing();
    logic [3:0] rd_exp [4];
    logic [3:0] bs_exp [4];
    rd_exp[0] = 4'd0; rd_exp[1] = 4'd0; rd_exp[2] = 4'd1; rd_exp[3] = 4'd0;
    bs_exp[0] = 4'd1; bs_exp[1] = 4'd1; bs_exp[2] = 4'd1; bs_exp[3] = 4'd0;
    expect1(1'b1, 1'b0, 32'd5, 32'd0);
    @(negedge clk);
    re = 1'b1; address = 32'd5;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      re = 1'b0;
      checks = checks + 1;
      if (ready !== rd_exp[k][0] || busy !== bs_exp[k][0]) begin
        errors = errors + 1;
        $display("FAIL read_timing_edge%0d: ready=%b busy=%b required ready=%b busy=%b",
                 k, ready, busy, rd_exp[k][0], bs_exp[k][0]);
      end
    end
    checks = checks + 1;
    if (data_out !== 32'hDEAD_BEEF) begin
      errors = errors + 1;
      $display("FAIL read_hold: data_out=%h required DEADBEEF", data_out);
    end
  endtask

  task automatic test_write_readback();
    req(1'b0, 1'b1, 32'd7, 32'h1234_5678);
    checks = checks + 1;
    if (data_out !== 32'hDEAD_BEEF) begin
      errors = errors + 1;
      $display("FAIL write_keeps_dout: data_out=%h required DEADBEEF", data_out);
    end
    req(1'b1, 1'b0, 32'd7, 32'd0);
  endtask

  task automatic test_errors();
    req(1'b1, 1'b0, 32'd300, 32'd0);
    req(1'b0, 1'b1, 32'h0000_0100, 32'hBAD0_BAD0);
    req(1'b1, 1'b0, 32'd0, 32'd0);
    req(1'b1, 1'b1, 32'd3, 32'hBAD3_BAD3);
    req(1'b1, 1'b0, 32'd3, 32'd0);
    req(1'b1, 1'b0, 32'h0100_0005, 32'd0);
    req(1'b1, 1'b0, 32'd255, 32'd0);
  endtask

  task automatic test_busy_ignore();
    int n;
    expect1(1'b1, 1'b0, 32'd7, 32'd0);
    expect1(1'b1, 1'b0, 32'd5, 32'd0);
    @(negedge clk);
    re = 1'b1; address = 32'd7;
    @(posedge clk);                       // capture read of 7
    @(negedge clk);
    re = 1'b0; we = 1'b1; address = 32'd3; data_in = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0; re = 1'b1; address = 32'd5;
    @(posedge clk);                       // enter RESP
    @(negedge clk);
    checks = checks + 1;
    if (ready !== 1'b1 || busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL busy_ignore_resp: ready=%b busy=%b required 1 1", ready, busy);
    end
    @(posedge clk);                       // RESP exit, re still high
    @(negedge clk);
    re = 1'b0;
    checks = checks + 1;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL back_to_back_capture: busy=%b ready=%b required 1 0", busy, ready);
    end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks = checks + 1;
    if (busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL busy_ignore_timeout: busy=%b required 0", busy);
    end
    req(1'b1, 1'b0, 32'd3, 32'd0);
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    we = 1'b1; address = 32'd9; data_in = 32'hAAAA_5555;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_last = 32'd0;
    checks = checks + 1;
    if ({ready, busy, err} !== 3'b000 || data_out !== 32'd0) begin
      errors = errors + 1;
      $display("FAIL reset_mid_write: ready=%b busy=%b err=%b data_out=%h required all 0",
               ready, busy, err, data_out);
    end
    repeat (4) @(negedge clk);
    req(1'b1, 1'b0, 32'd9, 32'd0);
  endtask

  task automatic test_latency1();
    exp_t x;
    x.d = 32'd0; x.e = 1'b0;
    q2.push_back(x);
    @(negedge clk);
    we2 = 1'b1; address2 = 32'd0; data_in2 = 32'h8C01_0004;
    @(posedge clk);
    @(negedge clk);
    we2 = 1'b0;
    checks = checks + 1;
    if (busy2 !== 1'b1 || ready2 !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL l1_capture: busy=%b ready=%b required 1 0", busy2, ready2);
    end
    @(posedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (ready2 !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL l1_write_ready: ready=%b required 1", ready2);
    end
    @(posedge clk);
    @(negedge clk);
    x.d = 32'h8C01_0004;
    repeat (3) q2.push_back(x);
    re2 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 4) re2 = 1'b0;
      checks = checks + 1;
      if (ready2 !== ((k % 2 == 1) ? 1'b1 : 1'b0)) begin
        errors = errors + 1;
        $display("FAIL l1_b2b_edge%0d: ready=%b required %b", k, ready2, (k % 2 == 1));
      end
    end
    checks = checks + 1;
    if (busy2 !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL l1_idle: busy=%b required 0", busy2);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_preload();
    test_read_timing();
    test_write_readback();
    test_errors();
    test_busy_ignore();
    test_reset_mid_write();
    test_latency1();
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors = errors + 1;
      $display("FAIL sb_drain: pending=%0d/%0d required 0/0", q1.size(), q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
